io_bus_arbiter: RTL and testbench
=================================

Name: io_bus_arbiter

Overview:
- Shares the 8-bit peripheral I/O bus between two requesters: m0 (CPU) and m1 (secondary master, e.g. loader or DMA).
- The bus carries address, din, w_en and r_en, and returns registered dout. The gpio and timer blocks hang off this bus.
- Arbitrates, issues exactly one single-cycle bus strobe per transaction, captures read data, and returns a one-cycle ack.

Parameters:
- ADDR_W, 8, bus address width
- DATA_W, 8, bus data width
- FIXED_PRIO, 0: 0 = round-robin; 1 = m0 always wins ties

Ports:
- clk  in  1  system clock
- rst  in  1  reset (see Behaviour)
- m0_req  in  1  m0 transaction request
- m0_we  in  1  1 = write, 0 = read
- m0_addr  in  ADDR_W  m0 target address
- m0_wdata  in  DATA_W  m0 write data
- m0_lock  in  1  hold grant after this transaction (see Optional Feature)
- m0_ack  out  1  one-cycle completion pulse
- m0_rdata  out  DATA_W  read data, valid from ack onward
- m1_req, m1_we, m1_addr, m1_wdata, m1_lock, m1_ack, m1_rdata: same as m0, for m1
- bus_address  out  ADDR_W  to peripheral address
- bus_din  out  DATA_W  to peripheral din
- bus_w_en  out  1  peripheral write strobe
- bus_r_en  out  1  peripheral read strobe
- bus_dout  in  DATA_W  OR-combined peripheral dout, registered by peripheral

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; last_grant = m1, so m0 wins the first tie.
- FSM states: IDLE, ISSUE, CAPTURE, ACK.
- IDLE:
  - req lines are sampled only here.
  - If any req is high, select a winner and latch its we/addr/wdata into internal registers, then go to ISSUE.
  - If no req is high, stay in IDLE.
- Winner selection:
  - Single request: that requester wins.
  - Both requesting, FIXED_PRIO=0: the requester not equal to last_grant wins.
  - Both requesting, FIXED_PRIO=1: m0 wins.
  - last_grant updates on every grant.
- ISSUE (exactly 1 cycle):
  - bus_address and bus_din are driven from the latched registers.
  - bus_w_en = we, bus_r_en = ~we.
  - Next state: write -> ACK; read -> CAPTURE.
- CAPTURE (reads only):
  - Strobes are 0.
  - bus_dout is valid this cycle and is registered into the winner's rdata at the end of the cycle.
  - Next state: ACK.
- ACK:
  - Winner's ack = 1 for exactly one cycle; the other ack stays 0.
  - Next state: IDLE.
- Latency from the IDLE cycle with req high: write ack at +2 cycles, read ack at +3 cycles.
- Fixed throughput: 1 write per 3 cycles, 1 read per 4 cycles.
- Strobes are never asserted outside ISSUE, and never both at once.
- bus_address and bus_din hold their last values while idle.
- Requester contract:
  - Keep req and fields stable until ack.
  - Deassert req in the cycle after ack unless starting a new transaction.
  - A req still high in the IDLE following ACK is treated as a new transaction.
- A losing requester keeps req high and is served next. With FIXED_PRIO=0, no starvation: two requests are interleaved strictly alternately.
- rdata of each master holds until that master's next read completes. Writes do not change rdata.
- Reset mid-transaction:
  - Immediately returns to IDLE with strobes and acks at 0.
  - The aborted transaction is never acked.
  - A write whose ISSUE edge had already occurred is not rolled back.
- Address and data widths pass through unmodified; no address decode here.

Optional Feature:
- Macro: IO_ARB_LOCK_EN.
- With the macro defined:
  - If the winner's lock is high in its ACK cycle, grant is held.
  - While held, IDLE considers only that master; the other is blocked even if requesting.
  - The hold ends at the first ACK where lock is low, or at reset.
  - Used for atomic read-modify-write of gpio port.
- Without the macro: lock ports exist but are ignored; arbitration as above.

Test Plan:
- m0 write addr 0x01 data 0xA5 -> bus_w_en=1 one cycle with bus_address=0x01, bus_din=0xA5; m0_ack at +2; bus_r_en never high.
- m1 read addr 0x02, bus_dout=0x3C in CAPTURE -> bus_r_en one cycle; m1_ack at +3 with m1_rdata=0x3C; m0_rdata unchanged.
- Both req in the same cycle after reset, FIXED_PRIO=0 -> m0 served first, then m1. Repeated contention alternates m0,m1,m0; FIXED_PRIO=1 -> m0 always first.
- Assert rst during a read's CAPTURE cycle -> state IDLE, no ack pulse, rdata=0; the next request completes normally.
- IO_ARB_LOCK_EN defined: m0 read with lock=1 while m1 requests, then m0 write lock=0 -> order m0 read, m0 write, m1. Macro undefined: order m0, m1, m0.

Source files
------------

// File: rtl/io_bus_arbiter_if.sv
// ----------------------------------------------------------------------------
// io_bus_arbiter_if
//
// Purpose:
//   Groups the two requester channels (m0 = CPU, m1 = secondary master) and
//   the shared 8-bit peripheral I/O bus that io_bus_arbiter sits between.
//
// Parameters:
//   ADDR_W - bus address width
//   DATA_W - bus data width
//
// Modports:
//   slave  - arbiter view: serves m0/m1 requests, drives the peripheral bus
//   master - environment view: requesters plus the peripheral dout return
//
// Signals per requester (mX = m0, m1):
//   mX_req, mX_we, mX_addr, mX_wdata, mX_lock  requester -> arbiter
//   mX_ack, mX_rdata                           arbiter -> requester
// Peripheral bus:
//   bus_address, bus_din, bus_w_en, bus_r_en   arbiter -> peripherals
//   bus_dout                                   peripherals -> arbiter
// ----------------------------------------------------------------------------
interface io_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
);

    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_lock;
    logic              m0_ack;
    logic [DATA_W-1:0] m0_rdata;

    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_lock;
    logic              m1_ack;
    logic [DATA_W-1:0] m1_rdata;

    logic [ADDR_W-1:0] bus_address;
    logic [DATA_W-1:0] bus_din;
    logic              bus_w_en;
    logic              bus_r_en;
    logic [DATA_W-1:0] bus_dout;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
        output m0_ack, m0_rdata,
        input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        output m1_ack, m1_rdata,
        output bus_address, bus_din, bus_w_en, bus_r_en,
        input  bus_dout
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m0_lock,
        input  m0_ack, m0_rdata,
        output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
        input  m1_ack, m1_rdata,
        input  bus_address, bus_din, bus_w_en, bus_r_en,
        output bus_dout
    );

endinterface

// File: rtl/io_bus_arbiter.sv
// ----------------------------------------------------------------------------
// io_bus_arbiter
//
// Purpose:
//   Shares the peripheral I/O bus (gpio, timer) between two requesters.
//   Each transaction gets exactly one single-cycle bus strobe; read data is
//   captured the cycle after the strobe and a one-cycle ack is returned to
//   the winning requester.
//
//   IDLE -> ISSUE -> ACK              (write, ack 2 cycles after the IDLE cycle)
//   IDLE -> ISSUE -> CAPTURE -> ACK   (read,  ack 3 cycles after the IDLE cycle)
//
// Parameters:
//   ADDR_W     - bus address width (must match the interface)
//   DATA_W     - bus data width (must match the interface)
//   FIXED_PRIO - 0: round-robin on ties, 1: m0 always wins ties
//
// Ports:
//   clk - system clock
//   rst - asynchronous, active-high reset
//   bus - io_bus_arbiter_if.slave: m0/m1 request channels and peripheral bus
//
// Optional feature (compile-time macro IO_ARB_LOCK_EN):
//   When defined, a winner whose lock input is high in its ACK cycle keeps
//   the grant; IDLE then only considers that master until an ACK with lock
//   low (or reset). Without the macro the lock inputs are ignored.
// ----------------------------------------------------------------------------
module io_bus_arbiter #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 8,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    io_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StIssue   = 2'd1,
        StCapture = 2'd2,
        StAck     = 2'd3
    } t_state;

    // Requester ids; last_grant resets to m1 so m0 wins the first tie.
    localparam logic ID_M0 = 1'b0;
    localparam logic ID_M1 = 1'b1;

    t_state            r_state;
    logic              r_last_grant;
    logic              r_winner;
    logic              r_we;
    logic [ADDR_W-1:0] r_bus_address;
    logic [DATA_W-1:0] r_bus_din;
    logic              r_bus_w_en;
    logic              r_bus_r_en;
    logic              r_m0_ack;
    logic              r_m1_ack;
    logic [DATA_W-1:0] r_m0_rdata;
    logic [DATA_W-1:0] r_m1_rdata;

`ifdef IO_ARB_LOCK_EN
    logic              r_lock_hold;
    logic              r_lock_owner;
`endif

    logic              w_m0_req;
    logic              w_m1_req;
    logic              w_any_req;
    logic              w_pick;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;

    // ------------------------------------------------------------------------
    // Winner selection (only acted upon in IDLE)
    // ------------------------------------------------------------------------
    always_comb begin
        w_m0_req = bus.m0_req;
        w_m1_req = bus.m1_req;
`ifdef IO_ARB_LOCK_EN
        // A held grant masks the other master completely.
        if (r_lock_hold) begin
            if (r_lock_owner == ID_M1) begin
                w_m0_req = 1'b0;
            end else begin
                w_m1_req = 1'b0;
            end
        end
`endif
        w_any_req = w_m0_req | w_m1_req;

        if (w_m0_req && w_m1_req) begin
            // Tie: fixed priority favours m0, round-robin favours the master
            // that did not win last time.
            w_pick = FIXED_PRIO ? ID_M0 : ~r_last_grant;
        end else begin
            w_pick = w_m1_req ? ID_M1 : ID_M0;
        end
    end

    always_comb begin
        w_sel_we    = bus.m0_we;
        w_sel_addr  = bus.m0_addr;
        w_sel_wdata = bus.m0_wdata;
        if (w_pick == ID_M1) begin
            w_sel_we    = bus.m1_we;
            w_sel_addr  = bus.m1_addr;
            w_sel_wdata = bus.m1_wdata;
        end
    end

    // ------------------------------------------------------------------------
    // Transaction FSM with registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= StIdle;
            r_last_grant  <= ID_M1;
            r_winner      <= ID_M0;
            r_we          <= 1'b0;
            r_bus_address <= '0;
            r_bus_din     <= '0;
            r_bus_w_en    <= 1'b0;
            r_bus_r_en    <= 1'b0;
            r_m0_ack      <= 1'b0;
            r_m1_ack      <= 1'b0;
            r_m0_rdata    <= '0;
            r_m1_rdata    <= '0;
`ifdef IO_ARB_LOCK_EN
            r_lock_hold   <= 1'b0;
            r_lock_owner  <= ID_M0;
`endif
        end else begin
            // Strobes and acks are single-cycle pulses unless set below.
            r_bus_w_en <= 1'b0;
            r_bus_r_en <= 1'b0;
            r_m0_ack   <= 1'b0;
            r_m1_ack   <= 1'b0;

            unique case (r_state)
                StIdle: begin
                    if (w_any_req) begin
                        r_winner     <= w_pick;
                        r_last_grant <= w_pick;
                        r_we         <= w_sel_we;
                        // The bus registers double as the transaction latch
                        // and hold their value afterwards while idle.
                        r_bus_address <= w_sel_addr;
                        r_bus_din     <= w_sel_wdata;
                        r_bus_w_en    <= w_sel_we;
                        r_bus_r_en    <= ~w_sel_we;
                        r_state       <= StIssue;
                    end
                end

                StIssue: begin
                    if (r_we) begin
                        r_m0_ack <= (r_winner == ID_M0);
                        r_m1_ack <= (r_winner == ID_M1);
                        r_state  <= StAck;
                    end else begin
                        r_state <= StCapture;
                    end
                end

                StCapture: begin
                    // Peripheral dout is registered, so it is valid one cycle
                    // after the read strobe.
                    if (r_winner == ID_M1) begin
                        r_m1_rdata <= bus.bus_dout;
                        r_m1_ack   <= 1'b1;
                    end else begin
                        r_m0_rdata <= bus.bus_dout;
                        r_m0_ack   <= 1'b1;
                    end
                    r_state <= StAck;
                end

                StAck: begin
`ifdef IO_ARB_LOCK_EN
                    r_lock_hold  <= (r_winner == ID_M1) ? bus.m1_lock : bus.m0_lock;
                    r_lock_owner <= r_winner;
`endif
                    r_state <= StIdle;
                end

                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.bus_address = r_bus_address;
    assign bus.bus_din     = r_bus_din;
    assign bus.bus_w_en    = r_bus_w_en;
    assign bus.bus_r_en    = r_bus_r_en;
    assign bus.m0_ack      = r_m0_ack;
    assign bus.m1_ack      = r_m1_ack;
    assign bus.m0_rdata    = r_m0_rdata;
    assign bus.m1_rdata    = r_m1_rdata;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// ----------------------------------------------------------------------------
// tb_io_bus_arbiter
//
// Directed bench for io_bus_arbiter. Two instances share identical inputs:
// u_dut_rr (round-robin) is the main checked instance, u_dut_fp (fixed
// priority) is checked in the contention scenario. Define IO_ARB_LOCK_EN
// for both RTL and bench to exercise the lock feature.
// ----------------------------------------------------------------------------
module tb_io_bus_arbiter;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    io_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) rr_if ();
    io_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) fp_if ();

    // Fixed-priority instance mirrors every input of the round-robin one.
    assign fp_if.m0_req   = rr_if.m0_req;
    assign fp_if.m0_we    = rr_if.m0_we;
    assign fp_if.m0_addr  = rr_if.m0_addr;
    assign fp_if.m0_wdata = rr_if.m0_wdata;
    assign fp_if.m0_lock  = rr_if.m0_lock;
    assign fp_if.m1_req   = rr_if.m1_req;
    assign fp_if.m1_we    = rr_if.m1_we;
    assign fp_if.m1_addr  = rr_if.m1_addr;
    assign fp_if.m1_wdata = rr_if.m1_wdata;
    assign fp_if.m1_lock  = rr_if.m1_lock;
    assign fp_if.bus_dout = rr_if.bus_dout;

    io_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b0)) u_dut_rr (
        .clk (clk),
        .rst (rst),
        .bus (rr_if.slave)
    );

    io_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1'b1)) u_dut_fp (
        .clk (clk),
        .rst (rst),
        .bus (fp_if.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Bus/ack monitor, sampled at the clock edge (values of the ending cycle).
    int rr_ack1_cnt  = 0;
    int rr_wen_cnt   = 0;
    int rr_ren_cnt   = 0;
    int strobe_clash = 0;
    int order_rr[$];
    int order_fp[$];

    always @(posedge clk) begin
        if (rr_if.m0_ack) order_rr.push_back(0);
        if (rr_if.m1_ack) begin
            order_rr.push_back(1);
            rr_ack1_cnt++;
        end
        if (rr_if.bus_w_en) rr_wen_cnt++;
        if (rr_if.bus_r_en) rr_ren_cnt++;
        if (rr_if.bus_w_en && rr_if.bus_r_en) strobe_clash++;
        if (fp_if.m0_ack) order_fp.push_back(0);
        if (fp_if.m1_ack) order_fp.push_back(1);
    end

    task automatic idle_inputs();
        rr_if.m0_req   = 1'b0;
        rr_if.m0_we    = 1'b0;
        rr_if.m0_addr  = '0;
        rr_if.m0_wdata = '0;
        rr_if.m0_lock  = 1'b0;
        rr_if.m1_req   = 1'b0;
        rr_if.m1_we    = 1'b0;
        rr_if.m1_addr  = '0;
        rr_if.m1_wdata = '0;
        rr_if.m1_lock  = 1'b0;
        rr_if.bus_dout = '0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    int base_wen;
    int base_ren;
    int base_ack1;
    int exp_rr[3];
    int exp_fp[3];
    int m0_stage;
    bit m1_done;
    bit pend0;
    bit pend1;
    bit done;

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        check_val("rst_m0_ack", {31'd0, rr_if.m0_ack}, 32'd0);
        check_val("rst_m1_ack", {31'd0, rr_if.m1_ack}, 32'd0);
        check_val("rst_w_en", {31'd0, rr_if.bus_w_en}, 32'd0);
        check_val("rst_r_en", {31'd0, rr_if.bus_r_en}, 32'd0);
        check_val("rst_addr", {24'd0, rr_if.bus_address}, 32'd0);
        check_val("rst_din", {24'd0, rr_if.bus_din}, 32'd0);
        check_val("rst_m0_rdata", {24'd0, rr_if.m0_rdata}, 32'd0);
        check_val("rst_m1_rdata", {24'd0, rr_if.m1_rdata}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // m0 write 0x01 <- 0xA5
        base_wen = rr_wen_cnt;
        base_ren = rr_ren_cnt;
        rr_if.m0_req   = 1'b1;
        rr_if.m0_we    = 1'b1;
        rr_if.m0_addr  = 8'h01;
        rr_if.m0_wdata = 8'hA5;
        @(negedge clk);
        check_val("wr_issue_w_en", {31'd0, rr_if.bus_w_en}, 32'd1);
        check_val("wr_issue_r_en", {31'd0, rr_if.bus_r_en}, 32'd0);
        check_val("wr_issue_addr", {24'd0, rr_if.bus_address}, 32'h01);
        check_val("wr_issue_din", {24'd0, rr_if.bus_din}, 32'hA5);
        check_val("wr_issue_ack", {31'd0, rr_if.m0_ack}, 32'd0);
        @(negedge clk);
        check_val("wr_ack_m0", {31'd0, rr_if.m0_ack}, 32'd1);
        check_val("wr_ack_m1", {31'd0, rr_if.m1_ack}, 32'd0);
        check_val("wr_ack_w_en", {31'd0, rr_if.bus_w_en}, 32'd0);
        rr_if.m0_req = 1'b0;
        @(negedge clk);
        check_val("wr_post_ack", {31'd0, rr_if.m0_ack}, 32'd0);
        check_val("wr_addr_hold", {24'd0, rr_if.bus_address}, 32'h01);
        check_val("wr_wen_count", rr_wen_cnt - base_wen, 32'd1);
        check_val("wr_ren_count", rr_ren_cnt - base_ren, 32'd0);

        // m1 read 0x02, peripheral returns 0x3C in CAPTURE
        rr_if.m1_req   = 1'b1;
        rr_if.m1_we    = 1'b0;
        rr_if.m1_addr  = 8'h02;
        rr_if.m1_wdata = 8'hEE;
        @(negedge clk);
        check_val("rd_issue_r_en", {31'd0, rr_if.bus_r_en}, 32'd1);
        check_val("rd_issue_w_en", {31'd0, rr_if.bus_w_en}, 32'd0);
        check_val("rd_issue_addr", {24'd0, rr_if.bus_address}, 32'h02);
        check_val("rd_issue_din", {24'd0, rr_if.bus_din}, 32'hEE);
        @(negedge clk);
        check_val("rd_cap_r_en", {31'd0, rr_if.bus_r_en}, 32'd0);
        check_val("rd_cap_ack", {31'd0, rr_if.m1_ack}, 32'd0);
        rr_if.bus_dout = 8'h3C;
        @(negedge clk);
        check_val("rd_ack_m1", {31'd0, rr_if.m1_ack}, 32'd1);
        check_val("rd_ack_m0", {31'd0, rr_if.m0_ack}, 32'd0);
        check_val("rd_m1_rdata", {24'd0, rr_if.m1_rdata}, 32'h3C);
        check_val("rd_m0_rdata", {24'd0, rr_if.m0_rdata}, 32'h00);
        rr_if.m1_req   = 1'b0;
        rr_if.bus_dout = 8'hFF;
        @(negedge clk);
        check_val("rd_post_ack", {31'd0, rr_if.m1_ack}, 32'd0);
        check_val("rd_rdata_hold", {24'd0, rr_if.m1_rdata}, 32'h3C);

        // Reset during CAPTURE of an m1 read
        base_ack1 = rr_ack1_cnt;
        rr_if.m1_req  = 1'b1;
        rr_if.m1_we   = 1'b0;
        rr_if.m1_addr = 8'h05;
        @(negedge clk);
        @(negedge clk);
        rr_if.bus_dout = 8'h77;
        rst = 1'b1;
        #1;
        check_val("rstmid_ack", {31'd0, rr_if.m1_ack}, 32'd0);
        check_val("rstmid_r_en", {31'd0, rr_if.bus_r_en}, 32'd0);
        check_val("rstmid_rdata", {24'd0, rr_if.m1_rdata}, 32'd0);
        rr_if.m1_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rstmid_no_ack", rr_ack1_cnt - base_ack1, 32'd0);
        check_val("rstmid_rdata_after", {24'd0, rr_if.m1_rdata}, 32'd0);

        // Next request after the aborted one completes normally
        rr_if.m0_req  = 1'b1;
        rr_if.m0_we   = 1'b0;
        rr_if.m0_addr = 8'h06;
        @(negedge clk);
        check_val("rec_r_en", {31'd0, rr_if.bus_r_en}, 32'd1);
        check_val("rec_addr", {24'd0, rr_if.bus_address}, 32'h06);
        @(negedge clk);
        rr_if.bus_dout = 8'h5A;
        @(negedge clk);
        check_val("rec_ack", {31'd0, rr_if.m0_ack}, 32'd1);
        check_val("rec_m0_rdata", {24'd0, rr_if.m0_rdata}, 32'h5A);
        check_val("rec_m1_rdata", {24'd0, rr_if.m1_rdata}, 32'h00);
        rr_if.m0_req   = 1'b0;
        rr_if.bus_dout = 8'h00;
        @(negedge clk);

        // Contention: both request together after reset and keep requesting
        pulse_reset();
        order_rr.delete();
        order_fp.delete();
        rr_if.m0_req   = 1'b1;
        rr_if.m0_we    = 1'b1;
        rr_if.m0_addr  = 8'h30;
        rr_if.m0_wdata = 8'h11;
        rr_if.m1_req   = 1'b1;
        rr_if.m1_we    = 1'b1;
        rr_if.m1_addr  = 8'h31;
        rr_if.m1_wdata = 8'h22;
        // Three writes at 3 cycles each; the third ack is in cycle 8.
        repeat (8) @(negedge clk);
        rr_if.m0_req = 1'b0;
        rr_if.m1_req = 1'b0;
        @(negedge clk);
        exp_rr[0] = 0; exp_rr[1] = 1; exp_rr[2] = 0;
        exp_fp[0] = 0; exp_fp[1] = 0; exp_fp[2] = 0;
        check_val("cont_rr_count", order_rr.size(), 32'd3);
        check_val("cont_fp_count", order_fp.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("cont_rr_order%0d", i),
                      (i < order_rr.size()) ? order_rr[i] : 99, exp_rr[i]);
            check_val($sformatf("cont_fp_order%0d", i),
                      (i < order_fp.size()) ? order_fp[i] : 99, exp_fp[i]);
        end

        // Lock scenario: m0 read (lock=1) vs m1 write, then m0 write (lock=0)
        pulse_reset();
        order_rr.delete();
        rr_if.bus_dout = 8'h42;
        rr_if.m0_req   = 1'b1;
        rr_if.m0_we    = 1'b0;
        rr_if.m0_addr  = 8'h10;
        rr_if.m0_lock  = 1'b1;
        rr_if.m1_req   = 1'b1;
        rr_if.m1_we    = 1'b1;
        rr_if.m1_addr  = 8'h20;
        rr_if.m1_wdata = 8'h33;
        m0_stage = 0;
        m1_done  = 1'b0;
        pend0    = 1'b0;
        pend1    = 1'b0;
        done     = 1'b0;
        // Requesters react to an ack in the following (IDLE) cycle.
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (pend0) begin
                pend0 = 1'b0;
                if (m0_stage == 0) begin
                    rr_if.m0_we    = 1'b1;
                    rr_if.m0_addr  = 8'h11;
                    rr_if.m0_wdata = 8'h44;
                    rr_if.m0_lock  = 1'b0;
                    m0_stage = 1;
                end else begin
                    rr_if.m0_req = 1'b0;
                    m0_stage = 2;
                end
            end
            if (pend1) begin
                pend1 = 1'b0;
                rr_if.m1_req = 1'b0;
                m1_done = 1'b1;
            end
            if (rr_if.m0_ack) pend0 = 1'b1;
            if (rr_if.m1_ack) pend1 = 1'b1;
            done = (m0_stage == 2) && m1_done;
        end
        check_val("lock_done", {31'd0, done}, 32'd1);
`ifdef IO_ARB_LOCK_EN
        exp_rr[0] = 0; exp_rr[1] = 0; exp_rr[2] = 1;
`else
        exp_rr[0] = 0; exp_rr[1] = 1; exp_rr[2] = 0;
`endif
        check_val("lock_count", order_rr.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("lock_order%0d", i),
                      (i < order_rr.size()) ? order_rr[i] : 99, exp_rr[i]);
        end
        check_val("lock_m0_rdata", {24'd0, rr_if.m0_rdata}, 32'h42);
        check_val("strobe_clash", strobe_clash, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
